// File: rtl/pause_pkg.sv
// Shared types and helpers for the pause / screen-dim controller.
//   state_e         : controller state (RUN, PAUSED, DIMMED)
//   cnt_width()     : bits needed to hold a value 0..max_val (minimum 1)
//   DIM_TICKS_DEF   : default pause-to-dim delay in clk_sys cycles
//   FADE_TICKS_DEF  : default cycles per fade step (PAUSE_FADE_EN builds)
package pause_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        DIMMED = 2'd2
    } state_e;

    localparam int unsigned DIM_TICKS_DEF  = 120000000;
    localparam int unsigned FADE_TICKS_DEF = 4000000;

    // Width of a counter that must reach max_val inclusive.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/rgb_attenuator.sv
// Combinational per-channel attenuator: each CH_W-bit channel of a packed
// {R,G,B} pixel is logically right-shifted by level (zero-filled).
//   rgb       in  3*CH_W  source pixel {R,G,B}
//   level     in  LVL_W   shift amount applied to every channel
//   rgb_att_c out 3*CH_W  attenuated pixel, combinational
module rgb_attenuator
    import pause_pkg::*;
#(
    parameter int unsigned CH_W  = 4,
    parameter int unsigned LVL_W = cnt_width(CH_W - 1)
) (
    input  logic [3*CH_W-1:0] rgb,
    input  logic [LVL_W-1:0]  level,
    output logic [3*CH_W-1:0] rgb_att_c
);

    // Shift each channel independently so no bits bleed between channels.
    always_comb begin
        rgb_att_c = '0;
        for (int c = 0; c < 3; c++) begin
            rgb_att_c[c*CH_W +: CH_W] = rgb[c*CH_W +: CH_W] >> level;
        end
    end

endmodule

// File: rtl/pause_dim_ctl.sv
// Pause and screen-dim controller for arcade cores.
// Merges a user pause toggle button with NUM_SRC level-held pause requests,
// and after DIM_TICKS cycles of pause attenuates the RGB stream by DIM_SHIFT.
// Optional macro PAUSE_FADE_EN: fade in the attenuation one step every
// FADE_TICKS cycles instead of jumping straight to DIM_SHIFT.
//   clk_sys     in  1        system clock
//   reset       in  1        synchronous, active-high reset
//   btn_pause   in  1        user pause button (rising edge toggles)
//   pause_req   in  NUM_SRC  external level pause requests
//   dim_en      in  1        1 = dimming allowed
//   rgb_in      in  3*CH_W   core pixel {R,G,B}
//   pause       out 1        combined pause to core (combinational)
//   dimmed      out 1        high while attenuation is applied
//   user_paused out 1        user toggle state
//   rgb_out     out 3*CH_W   registered, possibly attenuated pixel
module pause_dim_ctl
    import pause_pkg::*;
#(
    parameter int unsigned CH_W       = 4,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DIM_TICKS  = DIM_TICKS_DEF,
    parameter int unsigned DIM_SHIFT  = 1,
    parameter int unsigned FADE_TICKS = FADE_TICKS_DEF
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 btn_pause,
    input  logic [NUM_SRC-1:0]   pause_req,
    input  logic                 dim_en,
    input  logic [3*CH_W-1:0]    rgb_in,
    output logic                 pause,
    output logic                 dimmed,
    output logic                 user_paused,
    output logic [3*CH_W-1:0]    rgb_out
);

    localparam int unsigned RGB_W = 3 * CH_W;
    localparam int unsigned TMR_W = cnt_width(DIM_TICKS);
    localparam int unsigned LVL_W = cnt_width(CH_W - 1);

    if (NUM_SRC < 1 || DIM_TICKS < 1 || FADE_TICKS < 1 ||
        DIM_SHIFT < 1 || DIM_SHIFT >= CH_W) begin : g_bad_cfg
        $error("pause_dim_ctl: illegal parameter set");
    end

    logic               btn_prev;
    logic [TMR_W-1:0]   timer;
    logic               timer_sat_c;
    state_e             state_q;
    state_e             state_d;
    logic [LVL_W-1:0]   lvl_c;
    logic [RGB_W-1:0]   rgb_att_c;

    assign pause       = user_paused | (|pause_req);
    assign timer_sat_c = (timer == TMR_W'(DIM_TICKS));

    // Button edge detect, user toggle and pause timer.
    always_ff @(posedge clk_sys) begin
        btn_prev <= btn_pause;
        if (reset) begin
            user_paused <= 1'b0;
            timer       <= '0;
        end else begin
            if (btn_pause & ~btn_prev) begin
                user_paused <= ~user_paused;
            end
            if (!pause) begin
                timer <= '0;
            end else if (!timer_sat_c) begin
                timer <= timer + TMR_W'(1);
            end
        end
    end

    // State register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (!pause) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     state_d = PAUSED;
                PAUSED:  if (timer_sat_c && dim_en) state_d = DIMMED;
                DIMMED:  if (!dim_en) state_d = PAUSED;
                default: state_d = RUN;
            endcase
        end
    end

    // Attenuation level follows the state being entered, so the pixel
    // registered on the same edge already reflects unpause / dim_en changes.
`ifdef PAUSE_FADE_EN
    localparam int unsigned FADE_W = cnt_width(FADE_TICKS - 1);

    logic [FADE_W-1:0]  fade_cnt;
    logic [LVL_W-1:0]   fade_lvl;
    logic               fade_step_c;

    assign fade_step_c = (fade_cnt == FADE_W'(FADE_TICKS - 1));

    always_comb begin
        lvl_c = '0;
        if (state_d == DIMMED) begin
            if (state_q != DIMMED) begin
                lvl_c = LVL_W'(1);
            end else if (fade_step_c && (fade_lvl < LVL_W'(DIM_SHIFT))) begin
                lvl_c = fade_lvl + LVL_W'(1);
            end else begin
                lvl_c = fade_lvl;
            end
        end
    end

    // Step counter runs only while staying in DIMMED.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            fade_cnt <= '0;
            fade_lvl <= '0;
        end else begin
            fade_lvl <= lvl_c;
            if (state_d != DIMMED || state_q != DIMMED || fade_step_c) begin
                fade_cnt <= '0;
            end else begin
                fade_cnt <= fade_cnt + FADE_W'(1);
            end
        end
    end
`else
    always_comb begin
        lvl_c = '0;
        if (state_d == DIMMED) begin
            lvl_c = LVL_W'(DIM_SHIFT);
        end
    end
`endif

    rgb_attenuator #(
        .CH_W  (CH_W),
        .LVL_W (LVL_W)
    ) u_att (
        .rgb       (rgb_in),
        .level     (lvl_c),
        .rgb_att_c (rgb_att_c)
    );

    // Output pixel register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rgb_out <= '0;
            dimmed  <= 1'b0;
        end else begin
            rgb_out <= rgb_att_c;
            dimmed  <= (lvl_c != '0);
        end
    end

endmodule

// File: tb/tb_pause_dim_ctl.sv
// Directed self-checking bench for pause_dim_ctl (CH_W=4, NUM_SRC=2,
// DIM_TICKS=16, DIM_SHIFT=1, FADE_TICKS=4). With PAUSE_FADE_EN defined a
// second instance with DIM_SHIFT=3 exercises the fade ramp.
module tb_pause_dim_ctl;

    localparam int unsigned CH_W = 4;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic              btn_pause;
    logic [1:0]        pause_req;
    logic              dim_en;
    logic [3*CH_W-1:0] rgb_in;
    logic              pause;
    logic              dimmed;
    logic              user_paused;
    logic [3*CH_W-1:0] rgb_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    pause_dim_ctl #(
        .CH_W       (CH_W),
        .NUM_SRC    (2),
        .DIM_TICKS  (16),
        .DIM_SHIFT  (1),
        .FADE_TICKS (4)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .btn_pause   (btn_pause),
        .pause_req   (pause_req),
        .dim_en      (dim_en),
        .rgb_in      (rgb_in),
        .pause       (pause),
        .dimmed      (dimmed),
        .user_paused (user_paused),
        .rgb_out     (rgb_out)
    );

`ifdef PAUSE_FADE_EN
    logic              f_pause;
    logic              f_dimmed;
    logic              f_user_paused;
    logic [3*CH_W-1:0] f_rgb_out;

    pause_dim_ctl #(
        .CH_W       (CH_W),
        .NUM_SRC    (2),
        .DIM_TICKS  (16),
        .DIM_SHIFT  (3),
        .FADE_TICKS (4)
    ) dut_fade (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .btn_pause   (btn_pause),
        .pause_req   (pause_req),
        .dim_en      (dim_en),
        .rgb_in      (rgb_in),
        .pause       (f_pause),
        .dimmed      (f_dimmed),
        .user_paused (f_user_paused),
        .rgb_out     (f_rgb_out)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges; return 1 time unit after the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        btn_pause = 1'b0;
        pause_req = 2'b00;
        dim_en    = 1'b1;
        rgb_in    = 12'hFA6;
        tick(2);
        check("rst_pause",  32'(pause),       32'h0);
        check("rst_dimmed", 32'(dimmed),      32'h0);
        check("rst_user",   32'(user_paused), 32'h0);
        check("rst_rgb",    32'(rgb_out),     32'h0);
        reset = 1'b0;
        tick(1);
        check("run_rgb", 32'(rgb_out), 32'hFA6);

        // Button toggle: one toggle per press, held level ignored.
        btn_pause = 1'b1;
        tick(1);
        check("t1_user_on",  32'(user_paused), 32'h1);
        check("t1_pause_on", 32'(pause),       32'h1);
        tick(2);
        check("t1_user_held", 32'(user_paused), 32'h1);
        btn_pause = 1'b0;
        tick(2);
        check("t1_nodim", 32'(dimmed), 32'h0);
        btn_pause = 1'b1;
        tick(1);
        check("t1_user_off",  32'(user_paused), 32'h0);
        check("t1_pause_off", 32'(pause),       32'h0);
        btn_pause = 1'b0;
        tick(1);

        // User pause to dim at timer saturation, then unpause.
        btn_pause = 1'b1;
        tick(1);
        btn_pause = 1'b0;
        tick(16);
        check("t2_predim_d",   32'(dimmed),  32'h0);
        check("t2_predim_rgb", 32'(rgb_out), 32'hFA6);
        tick(1);
        check("t2_dim_rgb", 32'(rgb_out), 32'h753);
        check("t2_dim_d",   32'(dimmed),  32'h1);
        rgb_in = 12'h8C2;
        tick(1);
        check("t2_dim_live", 32'(rgb_out), 32'h461);
        btn_pause = 1'b1;
        tick(1);
        check("t2_unp_user",  32'(user_paused), 32'h0);
        check("t2_unp_pause", 32'(pause),       32'h0);
        btn_pause = 1'b0;
        tick(1);
        check("t2_unp_rgb", 32'(rgb_out), 32'h8C2);
        check("t2_unp_d",   32'(dimmed),  32'h0);
        rgb_in = 12'hFA6;

        // External request path.
        pause_req = 2'b10;
        #1;
        check("t3_pause_comb", 32'(pause), 32'h1);
        tick(16);
        check("t3_predim", 32'(dimmed), 32'h0);
        tick(1);
        check("t3_dim_d",   32'(dimmed),  32'h1);
        check("t3_dim_rgb", 32'(rgb_out), 32'h753);
        tick(3);
        check("t3_held_pause", 32'(pause), 32'h1);
        pause_req = 2'b00;
        #1;
        check("t3_release_pause", 32'(pause), 32'h0);
        tick(1);
        check("t3_release_rgb", 32'(rgb_out), 32'hFA6);
        check("t3_release_d",   32'(dimmed),  32'h0);
        // Timer restarts from zero after the release.
        pause_req = 2'b01;
        tick(16);
        check("t3_retimer_pre", 32'(dimmed), 32'h0);
        tick(1);
        check("t3_retimer_dim", 32'(dimmed), 32'h1);

        // User toggle off while a request holds pause: stays dimmed.
        btn_pause = 1'b1;
        tick(1);
        btn_pause = 1'b0;
        tick(1);
        btn_pause = 1'b1;
        tick(1);
        check("sim_user",  32'(user_paused), 32'h0);
        check("sim_pause", 32'(pause),       32'h1);
        btn_pause = 1'b0;
        tick(1);
        check("sim_dim", 32'(rgb_out), 32'h753);

        // dim_en drop and re-raise.
        dim_en = 1'b0;
        tick(1);
        check("t4_undim_rgb",   32'(rgb_out), 32'hFA6);
        check("t4_undim_d",     32'(dimmed),  32'h0);
        check("t4_undim_pause", 32'(pause),   32'h1);
        tick(1);
        check("t4_undim_hold", 32'(rgb_out), 32'hFA6);
        dim_en = 1'b1;
        tick(1);
        check("t4_redim_rgb", 32'(rgb_out), 32'h753);
        check("t4_redim_d",   32'(dimmed),  32'h1);

        // Reset while dimmed with the button held.
        pause_req = 2'b00;
        btn_pause = 1'b1;
        reset     = 1'b1;
        tick(1);
        check("t5_rst_pause", 32'(pause),       32'h0);
        check("t5_rst_d",     32'(dimmed),      32'h0);
        check("t5_rst_user",  32'(user_paused), 32'h0);
        check("t5_rst_rgb",   32'(rgb_out),     32'h0);
        reset = 1'b0;
        tick(2);
        check("t5_held_user", 32'(user_paused), 32'h0);
        check("t5_held_rgb",  32'(rgb_out),     32'hFA6);
        btn_pause = 1'b0;
        tick(1);
        check("t5_rel_user", 32'(user_paused), 32'h0);

`ifdef PAUSE_FADE_EN
        // Fade ramp with DIM_SHIFT=3: 777 x4, 333 x4, then 111 held.
        rgb_in    = 12'hFFF;
        pause_req = 2'b10;
        tick(17);
        check("t6_step1_a", 32'(f_rgb_out), 32'h777);
        check("t6_dimmed",  32'(f_dimmed),  32'h1);
        tick(3);
        check("t6_step1_b", 32'(f_rgb_out), 32'h777);
        tick(1);
        check("t6_step2_a", 32'(f_rgb_out), 32'h333);
        tick(3);
        check("t6_step2_b", 32'(f_rgb_out), 32'h333);
        tick(1);
        check("t6_step3_a", 32'(f_rgb_out), 32'h111);
        tick(4);
        check("t6_step3_hold", 32'(f_rgb_out), 32'h111);
        pause_req = 2'b00;
        tick(1);
        check("t6_exit", 32'(f_rgb_out), 32'hFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
